// File: rtl/nubus_mem_arbiter_pkg.sv
// Shared types and constants for the NuBus memory arbiter.
// Imported by the picker and the arbiter top.
package nubus_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  // Read data is only forwarded to a granted reader; everyone else sees zero.
  function automatic logic [31:0] gate_rdata(input logic en, input logic [31:0] data);
    return en ? data : 32'h0;
  endfunction

endpackage

// File: rtl/nubus_mem_arbiter_if.sv
// Requester A, requester B and memory-port signals of the arbiter.
// slave = the arbiter's view; master = the surrounding requesters and memory.
interface nubus_mem_arbiter_if;

  logic        a_valid;
  logic [3:0]  a_write;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_ready;
  logic        a_err;

  logic        b_valid;
  logic [3:0]  b_write;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic        b_ready;
  logic        b_err;

  logic        m_valid;
  logic [3:0]  m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic [1:0]  m_wait_clocks;
  logic [1:0]  grant_o;

  modport slave (
    input  a_valid, a_write, a_addr, a_wdata,
    output a_rdata, a_ready, a_err,
    input  b_valid, b_write, b_addr, b_wdata,
    output b_rdata, b_ready, b_err,
    output m_valid, m_write, m_addr, m_wdata,
    input  m_rdata, m_ready,
    output m_wait_clocks, grant_o
  );

  modport master (
    output a_valid, a_write, a_addr, a_wdata,
    input  a_rdata, a_ready, a_err,
    output b_valid, b_write, b_addr, b_wdata,
    input  b_rdata, b_ready, b_err,
    input  m_valid, m_write, m_addr, m_wdata,
    output m_rdata, m_ready,
    input  m_wait_clocks, grant_o
  );

endinterface

// File: rtl/nubus_mem_arbiter_rr.sv
// Two-way winner picker: round-robin or fixed A priority on contention.
// Holds the last-served pointer, updated only when a grant is taken.
module nubus_mem_arb_rr
  import nubus_mem_arb_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] winner,
  output logic       win_vld
);

  logic last_b;

  always_comb begin
    winner = GRANT_NONE;
    if (req[REQ_A] && req[REQ_B]) begin
      if (PRIORITY_MODE != 0 || last_b)
        winner[REQ_A] = 1'b1;
      else
        winner[REQ_B] = 1'b1;
    end else begin
      winner = req;
    end
  end

  assign win_vld = |req;

  // Reset to "B last served" so A wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_b <= 1'b1;
    else if (take && win_vld)
      last_b <= winner[REQ_B];
  end

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Shares one memory slave port between requesters A and B with an
// IDLE -> BUSY -> TURN sequence, per-requester wait states and timeout abort.
module nubus_mem_arbiter
  import nubus_mem_arb_pkg::*;
#(
  parameter int         PRIORITY_MODE = 0,
  parameter logic [1:0] WAIT_A        = 2'd1,
  parameter logic [1:0] WAIT_B        = 2'd0,
  parameter int         TIMEOUT       = 15,
  parameter int         TIMEOUT_W     = 4
) (
  input logic mem_clk,
  input logic mem_reset,
  nubus_mem_arbiter_if.slave bus
);

  // Counter value seen during the last BUSY cycle before abort.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  arb_state_t           state;
  logic [1:0]           grant;
  logic [TIMEOUT_W-1:0] tcnt;

  logic       gnt_a;
  logic       gnt_b;
  logic       sel_valid;
  logic       done;
  logic       tmo;
  logic       pick;
  logic [1:0] winner;
  logic       win_vld;

  assign pick = (state == IDLE);

  nubus_mem_arb_rr #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_rr (
    .clk     (mem_clk),
    .rst     (mem_reset),
    .req     ({bus.b_valid, bus.a_valid}),
    .take    (pick),
    .winner  (winner),
    .win_vld (win_vld)
  );

  always_comb begin
    gnt_a     = (state == BUSY) && grant[REQ_A];
    gnt_b     = (state == BUSY) && grant[REQ_B];
    sel_valid = (gnt_a && bus.a_valid) || (gnt_b && bus.b_valid);
    done      = sel_valid && bus.m_ready;
    tmo       = (TIMEOUT != 0) && sel_valid && !bus.m_ready && (tcnt == TO_LAST);
  end

  // Memory side follows the granted requester; all zero outside BUSY.
  always_comb begin
    bus.m_valid       = sel_valid;
    bus.m_write       = 4'h0;
    bus.m_addr        = 32'h0;
    bus.m_wdata       = 32'h0;
    bus.m_wait_clocks = 2'd0;
    if (gnt_a) begin
      bus.m_write       = bus.a_write;
      bus.m_addr        = bus.a_addr;
      bus.m_wdata       = bus.a_wdata;
      bus.m_wait_clocks = WAIT_A;
    end else if (gnt_b) begin
      bus.m_write       = bus.b_write;
      bus.m_addr        = bus.b_addr;
      bus.m_wdata       = bus.b_wdata;
      bus.m_wait_clocks = WAIT_B;
    end
  end

  always_comb begin
    bus.a_ready = gnt_a && done;
    bus.b_ready = gnt_b && done;
    bus.a_err   = gnt_a && tmo;
    bus.b_err   = gnt_b && tmo;
    bus.a_rdata = gate_rdata(gnt_a && (bus.a_write == 4'h0), bus.m_rdata);
    bus.b_rdata = gate_rdata(gnt_b && (bus.b_write == 4'h0), bus.m_rdata);
  end

  assign bus.grant_o = grant;

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state <= IDLE;
      grant <= GRANT_NONE;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state <= BUSY;
            grant <= winner;
            tcnt  <= '0;
          end
        end
        BUSY: begin
          // Completion, abort and requester withdrawal all end in TURN.
          if (!sel_valid || done || tmo) begin
            state <= TURN;
            grant <= GRANT_NONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Directed bench for nubus_mem_arbiter: one round-robin and one fixed-priority
// instance, each with a small wait-state memory model.
module tb_nubus_mem_arbiter;

  logic mem_clk = 1'b0;
  logic mem_reset;
  logic mem_en0;
  logic mem_en1;
  logic [1:0] wcnt0;
  logic [1:0] wcnt1;

  int n_checks;
  int n_fail;

  logic [1:0] seq0 [6];
  logic [1:0] seq1 [6];
  logic [1:0] exp0 [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp1 [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};

  always #5 mem_clk = ~mem_clk;

  nubus_mem_arbiter_if bus0 ();
  nubus_mem_arbiter_if bus1 ();

  nubus_mem_arbiter #(.PRIORITY_MODE(0)) dut0 (
    .mem_clk   (mem_clk),
    .mem_reset (mem_reset),
    .bus       (bus0)
  );

  nubus_mem_arbiter #(.PRIORITY_MODE(1)) dut1 (
    .mem_clk   (mem_clk),
    .mem_reset (mem_reset),
    .bus       (bus1)
  );

  // Memory: acknowledges after m_wait_clocks cycles of m_valid; Z when idle.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      wcnt0 <= 2'd0;
      wcnt1 <= 2'd0;
    end else begin
      wcnt0 <= (bus0.m_valid && !bus0.m_ready) ? wcnt0 + 2'd1 : 2'd0;
      wcnt1 <= (bus1.m_valid && !bus1.m_ready) ? wcnt1 + 2'd1 : 2'd0;
    end
  end

  assign bus0.m_ready = mem_en0 && bus0.m_valid && (wcnt0 == bus0.m_wait_clocks);
  assign bus1.m_ready = mem_en1 && bus1.m_valid && (wcnt1 == bus1.m_wait_clocks);
  assign bus0.m_rdata = bus0.m_valid ? (bus0.m_addr ^ 32'hDEAD_BEEF) : 32'bz;
  assign bus1.m_rdata = bus1.m_valid ? (bus1.m_addr ^ 32'hDEAD_BEEF) : 32'bz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.a_valid = 1'b0; bus0.a_write = 4'h0; bus0.a_addr = 32'h0; bus0.a_wdata = 32'h0;
    bus0.b_valid = 1'b0; bus0.b_write = 4'h0; bus0.b_addr = 32'h0; bus0.b_wdata = 32'h0;
    bus1.a_valid = 1'b0; bus1.a_write = 4'h0; bus1.a_addr = 32'h0; bus1.a_wdata = 32'h0;
    bus1.b_valid = 1'b0; bus1.b_write = 4'h0; bus1.b_addr = 32'h0; bus1.b_wdata = 32'h0;
  endtask

  task automatic do_reset();
    mem_reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge mem_clk);
    #1;
    mem_reset = 1'b0;
  endtask

  initial begin
    int ac0, bc0, ac1, bc1, n0, n1, errs, rdys;
    logic [1:0] prev0, prev1;

    n_checks = 0;
    n_fail   = 0;
    mem_en0  = 1'b1;
    mem_en1  = 1'b1;
    mem_reset = 1'b1;
    idle_inputs();

    // Reset state
    @(negedge mem_clk);
    check("rst grant", bus0.grant_o, 2'b00);
    check("rst m_valid", bus0.m_valid, 1'b0);
    check("rst wait", bus0.m_wait_clocks, 2'd0);
    check("rst a_rdata", bus0.a_rdata, 32'h0);
    tick();
    mem_reset = 1'b0;

    // Test 1: A-only read, wait 1
    bus0.a_valid = 1'b1;
    bus0.a_addr  = 32'h0000_1000;
    @(negedge mem_clk);
    check("t1 c0 m_valid", bus0.m_valid, 1'b0);
    tick();
    @(negedge mem_clk);
    check("t1 c1 m_valid", bus0.m_valid, 1'b1);
    check("t1 c1 grant", bus0.grant_o, 2'b01);
    check("t1 c1 wait", bus0.m_wait_clocks, 2'd1);
    check("t1 c1 m_addr", bus0.m_addr, 32'h0000_1000);
    check("t1 c1 a_ready", bus0.a_ready, 1'b0);
    tick();
    @(negedge mem_clk);
    check("t1 c2 a_ready", bus0.a_ready, 1'b1);
    check("t1 c2 a_rdata", bus0.a_rdata, 32'hDEAD_AEEF);
    check("t1 c2 b_ready", bus0.b_ready, 1'b0);
    check("t1 c2 b_rdata", bus0.b_rdata, 32'h0);
    tick();
    bus0.a_valid = 1'b0;
    @(negedge mem_clk);
    check("t1 c3 m_valid", bus0.m_valid, 1'b0);
    check("t1 c3 grant", bus0.grant_o, 2'b00);
    check("t1 c3 a_ready", bus0.a_ready, 1'b0);

    // Tests 2 and 3: contested writes, 3 accesses each, both priority modes
    do_reset();
    bus0.a_valid = 1'b1; bus0.a_write = 4'hF; bus0.a_addr = 32'h2000; bus0.a_wdata = 32'h1111_1111;
    bus0.b_valid = 1'b1; bus0.b_write = 4'h3; bus0.b_addr = 32'h3000; bus0.b_wdata = 32'h2222_2222;
    bus1.a_valid = 1'b1; bus1.a_write = 4'hF; bus1.a_addr = 32'h2000; bus1.a_wdata = 32'h1111_1111;
    bus1.b_valid = 1'b1; bus1.b_write = 4'h3; bus1.b_addr = 32'h3000; bus1.b_wdata = 32'h2222_2222;
    ac0 = 0; bc0 = 0; ac1 = 0; bc1 = 0; n0 = 0; n1 = 0;
    prev0 = 2'b00; prev1 = 2'b00;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge mem_clk);
      if (bus0.a_ready) ac0++;
      if (bus0.b_ready) bc0++;
      if (bus1.a_ready) ac1++;
      if (bus1.b_ready) bc1++;
      if (bus0.grant_o != 2'b00 && prev0 == 2'b00) begin
        check("t2 m_wdata", bus0.m_wdata,
              (bus0.grant_o == 2'b01) ? 32'h1111_1111 : 32'h2222_2222);
        if (n0 < 6) seq0[n0] = bus0.grant_o;
        n0++;
      end
      if (bus1.grant_o != 2'b00 && prev1 == 2'b00) begin
        if (n1 < 6) seq1[n1] = bus1.grant_o;
        n1++;
      end
      prev0 = bus0.grant_o;
      prev1 = bus1.grant_o;
      tick();
      bus0.a_valid = (ac0 < 3); bus0.b_valid = (bc0 < 3);
      bus1.a_valid = (ac1 < 3); bus1.b_valid = (bc1 < 3);
    end
    check("t2 grant count", n0, 6);
    check("t2 a done", ac0, 3);
    check("t2 b done", bc0, 3);
    for (int i = 0; i < 6; i++) begin
      if (i < n0) check($sformatf("t2 grant%0d", i), seq0[i], exp0[i]);
    end
    check("t3 grant count", n1, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < n1) check($sformatf("t3 grant%0d", i), seq1[i], exp1[i]);
    end

    // Test 4: B times out, memory never acknowledges
    do_reset();
    mem_en0 = 1'b0;
    bus0.b_valid = 1'b1;
    bus0.b_addr  = 32'h4000;
    errs = 0;
    rdys = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      @(negedge mem_clk);
      errs += int'(bus0.b_err);
      rdys += int'(bus0.b_ready);
    end
    check("t4 early err", errs, 0);
    check("t4 c14 grant", bus0.grant_o, 2'b10);
    tick();
    @(negedge mem_clk);
    check("t4 c15 b_err", bus0.b_err, 1'b1);
    check("t4 c15 b_ready", bus0.b_ready, 1'b0);
    check("t4 c15 a_err", bus0.a_err, 1'b0);
    tick();
    bus0.b_valid = 1'b0;
    @(negedge mem_clk);
    check("t4 c16 m_valid", bus0.m_valid, 1'b0);
    check("t4 c16 b_err", bus0.b_err, 1'b0);
    check("t4 c16 grant", bus0.grant_o, 2'b00);
    tick();
    @(negedge mem_clk);
    check("t4 c17 grant", bus0.grant_o, 2'b00);
    check("t4 no ready", rdys, 0);
    mem_en0 = 1'b1;

    // Test 5: A withdraws in its first BUSY cycle, B follows
    do_reset();
    bus0.a_valid = 1'b1; bus0.a_write = 4'hF; bus0.a_addr = 32'h5000;
    bus0.b_valid = 1'b1; bus0.b_write = 4'h0; bus0.b_addr = 32'h6000;
    tick();
    check("t5 c1 m_valid", bus0.m_valid, 1'b1);
    check("t5 c1 grant", bus0.grant_o, 2'b01);
    bus0.a_valid = 1'b0;
    #1;
    check("t5 drop m_valid", bus0.m_valid, 1'b0);
    check("t5 drop a_ready", bus0.a_ready, 1'b0);
    check("t5 drop a_err", bus0.a_err, 1'b0);
    tick();
    @(negedge mem_clk);
    check("t5 c2 grant", bus0.grant_o, 2'b00);
    tick();
    @(negedge mem_clk);
    check("t5 c3 grant", bus0.grant_o, 2'b00);
    tick();
    @(negedge mem_clk);
    check("t5 c4 grant", bus0.grant_o, 2'b10);
    check("t5 c4 wait", bus0.m_wait_clocks, 2'd0);
    check("t5 c4 b_ready", bus0.b_ready, 1'b1);
    check("t5 c4 b_rdata", bus0.b_rdata, 32'hDEAD_DEEF);
    check("t5 c4 a_rdata", bus0.a_rdata, 32'h0);
    check("t5 c4 a_ready", bus0.a_ready, 1'b0);
    tick();
    bus0.b_valid = 1'b0;

    // Test 6: reset during BUSY, then A wins the first contested grant
    do_reset();
    mem_en0 = 1'b0;
    bus0.a_valid = 1'b1; bus0.a_write = 4'h0; bus0.a_addr = 32'h7000;
    bus0.b_valid = 1'b1; bus0.b_write = 4'h0; bus0.b_addr = 32'h8000;
    tick();
    check("t6 busy grant", bus0.grant_o, 2'b01);
    check("t6 busy m_valid", bus0.m_valid, 1'b1);
    mem_reset = 1'b1;
    #1;
    check("t6 rst m_valid", bus0.m_valid, 1'b0);
    check("t6 rst grant", bus0.grant_o, 2'b00);
    check("t6 rst wait", bus0.m_wait_clocks, 2'd0);
    check("t6 rst a_rdata", bus0.a_rdata, 32'h0);
    check("t6 rst a_ready", bus0.a_ready, 1'b0);
    check("t6 rst a_err", bus0.a_err, 1'b0);
    @(negedge mem_clk);
    mem_reset = 1'b0;
    tick();
    check("t6 first grant", bus0.grant_o, 2'b01);

    mem_reset = 1'b1;
    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
